// File: rtl/reg_file_2r1w.sv
// 32-entry, two async read / one sync write integer register file; x0 reads zero, x2 resets to SP_INIT.
// Define REGFILE_WRITE_BYPASS_EN to forward WD3 to a read port addressing the register being written.
module reg_file_2r1w #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   input  logic                  WE3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic                             wr_ok;

   assign wr_ok = WE3 && (A3 != '0);

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (i == 2) ? SP_INIT : '0;
      end else if (wr_ok) begin
         mem[A3] <= WD3;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic byp1, byp2;

   // wr_ok already excludes A3==0, so a bypassed port never addresses x0.
   assign byp1 = wr_ok && (A1 == A3);
   assign byp2 = wr_ok && (A2 == A3);

   always_comb begin
      RD1 = '0;
      RD2 = '0;
      if (rst) begin
         if (byp1)            RD1 = WD3;
         else if (A1 != '0)   RD1 = mem[A1];
         if (byp2)            RD2 = WD3;
         else if (A2 != '0)   RD2 = mem[A2];
      end
   end
`else
   always_comb begin
      RD1 = '0;
      RD2 = '0;
      if (rst) begin
         if (A1 != '0) RD1 = mem[A1];
         if (A2 != '0) RD2 = mem[A2];
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: reset sweep, vector table, read-during-write and reset/write collision sequences.
module tb_reg_file_2r1w;

   localparam logic [31:0] SP = 32'h0000_8000;
`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [4:0]  A1, A2, A3;
   logic [31:0] WD3;
   logic        WE3;
   logic [31:0] RD1, RD2;

   reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INIT(SP)) dut (
      .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .WE3(WE3), .RD1(RD1), .RD2(RD2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   typedef struct {
      logic        we;
      logic [4:0]  a1, a2, a3;
      logic [31:0] wd;
      logic [31:0] e1, e2;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   n_cmp = 0;
   int   n_err = 0;

   // Drive one cycle of inputs, queue the expected reads, compare on the falling edge.
   task automatic step(input string nm, input logic r, input logic w,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [31:0] e1, input logic [31:0] e2);
      exp_t ex;
      rst = r; WE3 = w; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
      sb.push_back('{nm, e1, e2});
      @(negedge clk);
      ex = sb.pop_front();
      n_cmp++;
      if (RD1 !== ex.e1 || RD2 !== ex.e2) begin
         n_err++;
         $display("FAIL %s: RD1=%h RD2=%h, expected RD1=%h RD2=%h", ex.name, RD1, RD2, ex.e1, ex.e2);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

      // Two reset edges; outputs forced to zero even with a write and nonzero addresses.
      step("rst_hold0", 0, 1, 5'd2, 5'd31, 5'd5, 32'hCAFE_0000, 32'h0, 32'h0);
      step("rst_hold1", 0, 1, 5'd5, 5'd2,  5'd5, 32'hCAFE_0001, 32'h0, 32'h0);

      // Post-reset sweep: only x2 is nonzero.
      for (int i = 0; i < 32; i++)
         step($sformatf("rst_sweep_%0d", i), 1, 0, 5'(i), 5'(31 - i), 5'd0, 32'h0,
              (i == 2) ? SP : 32'h0, (31 - i == 2) ? SP : 32'h0);

      vecs[0]  = '{1, 5'd0,  5'd2,  5'd5,  32'hDEAD_BEEF, 32'h0,         SP};
      vecs[1]  = '{0, 5'd5,  5'd5,  5'd0,  32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[2]  = '{1, 5'd5,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0};
      vecs[3]  = '{0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
      vecs[4]  = '{0, 5'd7,  5'd7,  5'd7,  32'h1234_5678, 32'h0,         32'h0};
      vecs[5]  = '{0, 5'd7,  5'd7,  5'd0,  32'h0,         32'h0,         32'h0};
      vecs[6]  = '{1, 5'd5,  5'd2,  5'd9,  32'h0000_0001, 32'hDEAD_BEEF, SP};
      vecs[7]  = '{1, 5'd9,  5'd9,  5'd31, 32'hA5A5_A5A5, 32'h1,         32'h1};
      vecs[8]  = '{0, 5'd31, 5'd9,  5'd0,  32'h0,         32'hA5A5_A5A5, 32'h1};
      vecs[9]  = '{1, 5'd31, 5'd0,  5'd2,  32'h0000_1234, 32'hA5A5_A5A5, 32'h0};
      vecs[10] = '{0, 5'd2,  5'd2,  5'd0,  32'h0,         32'h0000_1234, 32'h0000_1234};
      for (int i = 0; i < 11; i++)
         step($sformatf("vec_%0d", i), 1, vecs[i].we, vecs[i].a1, vecs[i].a2, vecs[i].a3,
              vecs[i].wd, vecs[i].e1, vecs[i].e2);

      // Read-during-write on x9 (holds 1): old value unless bypass is built in.
      step("rdw_same", 1, 1, 5'd9, 5'd9, 5'd9, 32'h2, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1);
      step("rdw_after", 1, 0, 5'd9, 5'd0, 5'd0, 32'h0, 32'h2, 32'h0);
      step("rdw_x0", 1, 1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
      step("rdw_one_port", 1, 1, 5'd5, 5'd31, 5'd31, 32'h7777_7777, 32'hDEAD_BEEF, BYP ? 32'h7777_7777 : 32'hA5A5_A5A5);

      // Reset beats a same-edge write, and wipes everything written so far.
      step("col_wr", 1, 1, 5'd0, 5'd0, 5'd3, 32'hAA, 32'h0, 32'h0);
      step("col_chk", 1, 0, 5'd3, 5'd3, 5'd0, 32'h0, 32'hAA, 32'hAA);
      step("col_rst", 0, 1, 5'd3, 5'd9, 5'd3, 32'h55, 32'h0, 32'h0);
      step("col_x3", 1, 0, 5'd3, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0);
      step("col_x2", 1, 0, 5'd2, 5'd31, 5'd0, 32'h0, SP, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Architectural integer register file for the single-cycle RISC-V core.
- Sits directly upstream of the ALU. RD1 drives ALU operand A; RD2 drives the B-side operand mux (the immediate mux chooses between RD2 and the immediate).
- Provides two asynchronous read ports and one synchronous write port from writeback.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits (XLEN).
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- SP_INIT, 32'h0000_0000, value loaded into x2 (sp) on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- A1  input  ADDR_WIDTH  read address port 1 (instr[19:15], rs1).
- A2  input  ADDR_WIDTH  read address port 2 (instr[24:20], rs2).
- A3  input  ADDR_WIDTH  write address (instr[11:7], rd).
- WD3  input  DATA_WIDTH  write data from the writeback mux.
- WE3  input  1  write enable (RegWrite from the control unit).
- RD1  output  DATA_WIDTH  read data 1, to ALU operand A.
- RD2  output  DATA_WIDTH  read data 2, to the ALU B-side mux and store data.

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits. Entry 0 is not writable and always reads 0.
- Reset:
  - rst is sampled only on the rising clk edge (synchronous, active-low).
  - When rst==0 at an edge: all entries clear to 0, except x2, which loads SP_INIT.
  - Reset takes priority over any write in the same cycle; WE3 is ignored.
  - While rst==0, RD1 and RD2 are forced to 0 combinationally, regardless of A1/A2.
  - A reset asserted mid-program discards all register contents at the next edge. No partial state is retained.
- Write:
  - On a rising edge with rst==1, WE3==1 and A3!=0: mem[A3] <= WD3.
  - WE3==1 with A3==0 is a no-op. No state changes.
  - WE3==0: no state changes.
- Read:
  - Combinational, zero-cycle latency: RD1 = (A1==0) ? 0 : mem[A1]; RD2 likewise with A2.
  - A1==A2 is legal; both ports return the same value.
- Read-during-write (A1 or A2 equals A3, WE3==1, same cycle): the default build returns the OLD stored value. The new value is visible from the cycle after the edge. See the optional feature for the alternative.
- No handshake: the single-cycle core guarantees one instruction per clock. The block never stalls.
- Index width: addresses are exactly ADDR_WIDTH bits, so there is no out-of-range access.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When rst==1, WE3==1, A3!=0 and A1==A3, RD1 returns WD3 combinationally in the same cycle. RD2 behaves the same way when A2==A3.
  - x0 reads still return 0.
  - This build is used when the core is later pipelined (WB to ID forwarding).
- Undefined: the read-old-value behaviour described under Behaviour applies. No bypass logic is generated.

Test Plan:
- Reset contents: hold rst=0 for 2 edges, release, set A1 from 0 to 31 -> RD1 = 0 for every index except x2, which equals SP_INIT; while rst=0, RD1=RD2=0 for any address.
- Basic write/read: write x5=32'hDEAD_BEEF (WE3=1, A3=5), next cycle A1=5, A2=5 -> RD1=RD2=32'hDEAD_BEEF.
- x0 protection: WE3=1, A3=0, WD3=32'hFFFF_FFFF, next cycle A1=0 -> RD1=0.
- Write disabled: WE3=0, A3=7, WD3=32'h1234_5678, next cycle A2=7 -> RD2 unchanged (0 after reset).
- Read-during-write: x9=32'h1 stored, then same cycle WE3=1, A3=9, WD3=32'h2, A1=9 -> RD1=32'h1 without the macro, 32'h2 with REGFILE_WRITE_BYPASS_EN; after the edge, RD1=32'h2 in both builds.
- Reset vs write collision: x3=32'hAA stored, then rst=0 with WE3=1, A3=3, WD3=32'h55 at the same edge, then rst=1 -> x3 reads 0.
